systolic_array: RTL and testbench

- Row of NUM_UNITS independent IEEE-754 half-precision (FP16) multiply units sharing one start strobe and one per-unit enable mask.
- On start, every enabled unit captures its operand pair and produces the product a*b after a fixed latency. It then pulses its ready bit.
- Serves as the multiply stage of the toy TPU datapath; accumulation happens downstream.

---
 rtl/systolic_pkg.sv | 55 +++++
 rtl/fp16_mul_unit.sv | 157 +++++++++++++++
 rtl/systolic_array.sv | 34 +++
 tb/tb_systolic_array.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared FP16 definitions for the systolic multiply row: field widths,
// special-value constants, the per-unit FSM encoding and the MUL->NORM
// pipeline record, plus small classification helpers.
package systolic_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int BIAS      = 15;
    localparam int SIG_W     = FRAC_W + 1;       // hidden one + fraction
    localparam int PROD_W    = 2 * SIG_W;        // full significand product
    localparam int EXP_SUM_W = 7;                // signed biased exponent sum

    typedef logic [EXP_W+FRAC_W:0] fp16_t;

    localparam fp16_t QNAN    = 16'h7E00;
    localparam fp16_t POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } unit_state_e;

    // Everything the NORM step needs, captured at the end of MUL.
    typedef struct packed {
        logic                 sign;
        logic [EXP_SUM_W-1:0] exp_sum;      // two's complement
        logic [PROD_W-1:0]    prod;
        logic                 special;      // special_val overrides rounding
        fp16_t                special_val;
    } mul_stage_t;

    function automatic logic [EXP_W-1:0] exp_of(input fp16_t x);
        return x[EXP_W+FRAC_W-1:FRAC_W];
    endfunction

    function automatic logic [FRAC_W-1:0] frac_of(input fp16_t x);
        return x[FRAC_W-1:0];
    endfunction

    function automatic logic is_nan(input fp16_t x);
        return (exp_of(x) == '1) && (frac_of(x) != '0);
    endfunction

    function automatic logic is_inf(input fp16_t x);
        return (exp_of(x) == '1) && (frac_of(x) == '0);
    endfunction

    // Subnormals are flushed: any zero exponent field counts as zero.
    function automatic logic is_zero(input fp16_t x);
        return exp_of(x) == '0;
    endfunction

endpackage

// File: rtl/fp16_mul_unit.sv
// One FP16 multiply unit: latches an operand pair on start, forms the
// significand product, normalises and rounds to nearest-even with
// flush-to-zero, then presents the product with a one-cycle ready pulse.
module fp16_mul_unit
    import systolic_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t result,
    output logic  ready
);

    unit_state_e state_q, state_d;
    fp16_t       a_q, a_d;
    fp16_t       b_q, b_d;
    mul_stage_t  mul_q, mul_d;
    fp16_t       norm_q, norm_d;
    fp16_t       result_q, result_d;
    logic        ready_q, ready_d;

    mul_stage_t  mul_calc;
    fp16_t       norm_calc;

    logic [FRAC_W-1:0]    mant_t;
    logic                 guard_bit;
    logic                 sticky_bit;
    logic                 round_up;
    logic [FRAC_W:0]      mant_r;
    logic [EXP_SUM_W-1:0] exp_n;

    // MUL step: sign, biased exponent sum, significand product, special cases.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/else chain can leave a latch behind.
        mul_calc             = '0;
        mul_calc.sign        = a_q[EXP_W+FRAC_W] ^ b_q[EXP_W+FRAC_W];
        mul_calc.exp_sum     = {2'b00, exp_of(a_q)} + {2'b00, exp_of(b_q)}
                               - EXP_SUM_W'(BIAS);
        mul_calc.prod        = PROD_W'({1'b1, frac_of(a_q)})
                               * PROD_W'({1'b1, frac_of(b_q)});
        mul_calc.special     = 1'b0;
        mul_calc.special_val = '0;
        if (is_nan(a_q) || is_nan(b_q)
            || (is_inf(a_q) && is_zero(b_q))
            || (is_zero(a_q) && is_inf(b_q))) begin
            mul_calc.special     = 1'b1;
            mul_calc.special_val = QNAN;
        end else if (is_inf(a_q) || is_inf(b_q)) begin
            mul_calc.special     = 1'b1;
            mul_calc.special_val = {mul_calc.sign, POS_INF[EXP_W+FRAC_W-1:0]};
        end else if (is_zero(a_q) || is_zero(b_q)) begin
            mul_calc.special     = 1'b1;
            mul_calc.special_val = {mul_calc.sign, {(EXP_W+FRAC_W){1'b0}}};
        end
    end

    // NORM step: normalise, round to nearest-even, saturate or flush.
    always_comb begin
        mant_t     = '0;
        guard_bit  = 1'b0;
        sticky_bit = 1'b0;
        exp_n      = mul_q.exp_sum;
        if (mul_q.prod[PROD_W-1]) begin
            mant_t     = mul_q.prod[PROD_W-2:SIG_W];
            guard_bit  = mul_q.prod[FRAC_W];
            sticky_bit = |mul_q.prod[FRAC_W-1:0];
            exp_n      = exp_n + EXP_SUM_W'(1);
        end else begin
            mant_t     = mul_q.prod[PROD_W-3:FRAC_W];
            guard_bit  = mul_q.prod[FRAC_W-1];
            sticky_bit = |mul_q.prod[FRAC_W-2:0];
        end
        round_up = guard_bit & (sticky_bit | mant_t[0]);
        mant_r   = {1'b0, mant_t} + {{FRAC_W{1'b0}}, round_up};
        // A carry out of the fraction means 1.111..1 rounded up to 10.000..0:
        // the fraction bits are already zero, only the exponent moves.
        if (mant_r[FRAC_W]) begin
            exp_n = exp_n + EXP_SUM_W'(1);
        end
        if (mul_q.special) begin
            norm_calc = mul_q.special_val;
        end else if ($signed(exp_n) >= $signed(EXP_SUM_W'(31))) begin
            norm_calc = {mul_q.sign, POS_INF[EXP_W+FRAC_W-1:0]};
        end else if ($signed(exp_n) <= $signed(EXP_SUM_W'(0))) begin
            norm_calc = {mul_q.sign, {(EXP_W+FRAC_W){1'b0}}};
        end else begin
            norm_calc = {mul_q.sign, exp_n[EXP_W-1:0], mant_r[FRAC_W-1:0]};
        end
    end

    // Unit FSM: next state, operand capture, stage loads and output update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mul_d    = mul_q;
        norm_d   = norm_q;
        result_d = result_q;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL;
                end
            end
            MUL: begin
                mul_d   = mul_calc;
                state_d = NORM;
            end
            NORM: begin
                norm_d  = norm_calc;
                state_d = DONE;
            end
            DONE: begin
                result_d = norm_q;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath holding registers.
    always_ff @(posedge clk) begin
        // NOTE: operand and pipeline registers are deliberately not reset;
        // the FSM always writes them before reading them, and resetting the
        // control state alone is enough to discard an in-flight operation.
        a_q    <= a_d;
        b_q    <= b_d;
        mul_q  <= mul_d;
        norm_q <= norm_d;
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: rtl/systolic_array.sv
// Row of independent FP16 multiply units sharing one start strobe; each
// unit is gated by its bit of active_units and reports its own ready pulse.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_UNITS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_UNITS-1:0]       active_units,
    input  logic [NUM_UNITS*WIDTH-1:0] a_in_array,
    input  logic [NUM_UNITS*WIDTH-1:0] b_in_array,
    output logic [NUM_UNITS*WIDTH-1:0] result_array,
    output logic [NUM_UNITS-1:0]       ready_array
);

    fp16_t unit_result [NUM_UNITS];

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        fp16_mul_unit u_mul (
            .clk    (clk),
            .reset  (reset),
            .start  (start & active_units[i]),
            .a      (a_in_array[i*WIDTH +: WIDTH]),
            .b      (b_in_array[i*WIDTH +: WIDTH]),
            .result (unit_result[i]),
            .ready  (ready_array[i])
        );
        assign result_array[i*WIDTH +: WIDTH] = unit_result[i];
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: hand-computed FP16 products, latency,
// mask gating, busy-start rejection and reset abort.
module tb_systolic_array;

    localparam int W = 16;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   active_units;
    logic [N*W-1:0] a_in_array;
    logic [N*W-1:0] b_in_array;
    logic [N*W-1:0] result_array;
    logic [N-1:0]   ready_array;

    int n_cmp = 0;
    int n_bad = 0;

    systolic_array #(.WIDTH(W), .NUM_UNITS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .active_units (active_units),
        .a_in_array   (a_in_array),
        .b_in_array   (b_in_array),
        .result_array (result_array),
        .ready_array  (ready_array)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one edge, then scramble them.
    task automatic pulse_start(input logic [N-1:0] mask, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b);
        active_units = mask;
        a_in_array   = a;
        b_in_array   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        a_in_array = {N{16'h7E00}};
        b_in_array = {N{16'h7E00}};
    endtask

    // Launch and check: ready low before edge N+3, then ready/results after it.
    task automatic do_op(input string tag, input logic [N-1:0] mask,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [N*W-1:0] exp_res);
        pulse_start(mask, a, b);
        wait_edges(2);
        check({tag, " early ready"}, 64'(ready_array), 64'(0));
        wait_edges(1);
        check({tag, " ready"}, 64'(ready_array), 64'(mask));
        check({tag, " result"}, 64'(result_array), 64'(exp_res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        active_units = '0;
        a_in_array   = '0;
        b_in_array   = '0;
        wait_edges(1);
        check("reset result", 64'(result_array), 64'(0));
        check("reset ready", 64'(ready_array), 64'(0));
        reset = 1'b1;
        wait_edges(1);

        // Vectors are packed {unit2, unit1, unit0}.
        do_op("basic", 3'b111,
              {16'hBC00, 16'h4200, 16'h4000},
              {16'h3C00, 16'h3800, 16'h4000},
              {16'hBC00, 16'h3E00, 16'h4400});
        wait_edges(1);
        check("basic pulse width", 64'(ready_array), 64'(0));

        do_op("b2b first", 3'b111,
              {16'h3C00, 16'h3C00, 16'h3C00},
              {16'h4000, 16'h4000, 16'h3C00},
              {16'h4000, 16'h4000, 16'h3C00});
        do_op("b2b second", 3'b111,
              {16'h3C00, 16'h3C00, 16'h4000},
              {16'h4000, 16'h4000, 16'h4000},
              {16'h4000, 16'h4000, 16'h4400});

        do_op("special ovf/zero/negzero", 3'b111,
              {16'h8000, 16'h0000, 16'h7BFF},
              {16'h3C00, 16'h4000, 16'h4000},
              {16'h8000, 16'h0000, 16'h7C00});
        do_op("special infx0/ftz/round", 3'b111,
              {16'h3C01, 16'h0400, 16'h7C00},
              {16'h3C01, 16'h0400, 16'h0000},
              {16'h3C02, 16'h0000, 16'h7E00});
        do_op("special nan/neginf/neg", 3'b111,
              {16'hC000, 16'hFC00, 16'h7E00},
              {16'h3800, 16'h4000, 16'h3C00},
              {16'hBC00, 16'hFC00, 16'h7E00});
        do_op("rne tie up/tie even/shift", 3'b111,
              {16'h3BFF, 16'h3E00, 16'h3E00},
              {16'h3C01, 16'h3C03, 16'h3C01},
              {16'h3C00, 16'h3E04, 16'h3E02});

        // Unit 1 masked off: keeps 3E04 from the previous operation.
        do_op("mask 101", 3'b101,
              {16'h4000, 16'h4400, 16'h4000},
              {16'h4000, 16'h4400, 16'h3C00},
              {16'h4400, 16'h3E04, 16'h4000});
        wait_edges(1);
        check("mask pulse width", 64'(ready_array), 64'(0));

        // Second start one cycle into the operation must be ignored.
        pulse_start(3'b111, {N{16'h3C00}}, {N{16'h4000}});
        active_units = 3'b111;
        a_in_array   = {N{16'h4400}};
        b_in_array   = {N{16'h4400}};
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_edges(1);
        check("busy early ready", 64'(ready_array), 64'(0));
        wait_edges(1);
        check("busy ready", 64'(ready_array), 64'(3'b111));
        check("busy result", 64'(result_array), 64'({N{16'h4000}}));
        for (int k = 0; k < 3; k++) begin
            wait_edges(1);
            check($sformatf("busy no repeat %0d", k), 64'(ready_array), 64'(0));
        end

        // Reset while the units sit in MUL: outputs cleared, no ready later.
        pulse_start(3'b111, {N{16'h4400}}, {N{16'h4000}});
        reset = 1'b0;
        wait_edges(1);
        check("abort result", 64'(result_array), 64'(0));
        check("abort ready", 64'(ready_array), 64'(0));
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_edges(1);
            check($sformatf("abort no ready %0d", k), 64'(ready_array), 64'(0));
        end
        check("abort result held", 64'(result_array), 64'(0));

        do_op("after abort", 3'b111,
              {16'hBC00, 16'h4200, 16'h4000},
              {16'h3C00, 16'h3800, 16'h4000},
              {16'hBC00, 16'h3E00, 16'h4400});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
